// File: rtl/mem_responder.sv
// Word-addressed RAM responder for the MAR/Read/Write/Mdatain datapath interface.
// A request accepted in IDLE completes WAIT_CYCLES+1 edges later, marked by a one-cycle Ready pulse.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              MARin,
  input  logic [31:0]       BusMuxOut,
  input  logic [31:0]       MDR_output,
  input  logic              Read,
  input  logic              Write,
  output logic [31:0]       Mdatain,
  output logic              Ready,
  output logic              Busy,
  output logic [ADDR_W-1:0] Address
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] mar_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mdatain_q;
  logic [31:0]       mem [DEPTH];
  logic              mem_we;
  logic              unused_bus;

  // Upper bus bits never reach the MAR; the address wraps at ADDR_W.
  assign unused_bus = ^BusMuxOut[31:ADDR_W];

  assign mem_we = (state_q == WR_WAIT) && (cnt_q == 4'd0);

  // RAM contents survive Clear, so the array sits outside the reset domain.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem[req_addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      mar_q      <= '0;
      req_addr_q <= '0;
      wdata_q    <= '0;
      mdatain_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MARin) begin
            mar_q <= BusMuxOut[ADDR_W-1:0];
          end
          // req_addr takes the pre-edge MAR; a same-edge MARin affects only later requests.
          if (Read || Write) begin
            req_addr_q <= mar_q;
            cnt_q      <= CNT_INIT;
            state_q    <= Read ? RD_WAIT : WR_WAIT;
          end
          if (Write && !Read) begin
            wdata_q <= MDR_output;
          end
        end
        RD_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            mdatain_q <= mem[req_addr_q];
            state_q   <= DONE;
          end
        end
        WR_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Busy    = (state_q != IDLE);
  assign Ready   = (state_q == DONE);
  assign Mdatain = mdatain_q;
  assign Address = mar_q;

endmodule
